mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

- Memory-stage SRAM access controller for the 16-bit pipeline.
- Turns a single-cycle load/store request, carried on the same 2-bit memory-control encoding as the memory-stage result path, into a multi-cycle external SRAM bus sequence.
- Stalls the pipeline with `busy` until the sequence completes.
- Returns load data as `readData`, the registered word the memory-stage result mux selects when control bit 1 is set.

## Interface
Parameters:
- `STROBE_CYCLES`, default 2: number of cycles `ramWe_n`/`ramOe_n` is held low; legal range 1..15.
- `ADDR_W`, default 16: external SRAM address width.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `reqValid` input 1: request strobe; sampled only in IDLE.
- `memControl` input 2: bit1 = read (load), bit0 = write (store), 00 = no access.
- `addrIn` input ADDR_W: access address.
- `dataIn` input 16: store data.
- `busy` output 1: high whenever state is not IDLE.
- `readData` output 16: last captured load word; held until the next load.
- `readValid` output 1: one-cycle pulse when `readData` is updated.
- `writeDone` output 1: one-cycle pulse at store completion.
- `illegalReq` output 1: one-cycle pulse when `memControl` is 11 on an accepted request.
- `verifyErr` output 1: sticky write-verify mismatch flag; see Configuration.
- `ramAddr` output ADDR_W: SRAM address.
- `ramDataOut` output 16: SRAM write data.
- `ramDataOe` output 1: tristate enable for `ramDataOut` (1 = drive).
- `ramDataIn` input 16: SRAM read data.
- `ramCe_n`, `ramOe_n`, `ramWe_n` output 1 each: active-low SRAM strobes.

## Operation
- States: IDLE, WSETUP, WSTROBE, WHOLD, RSETUP, RSTROBE, RDONE, plus VSETUP, VSTROBE, VDONE when verify is compiled in.
- Accept: in IDLE with `reqValid`=1 and `memControl`≠00, latch `addrIn`, `dataIn` and the operation.
  - Requests arriving while `busy` is high are ignored. Upstream holds the request until `busy` falls.
- Encoding 11 is treated as a read: `illegalReq` pulses in the first cycle after accept and the write is dropped.
- Write path: WSETUP (1 cycle) → WSTROBE (STROBE_CYCLES) → WHOLD (1 cycle) → IDLE. `writeDone`=1 during WHOLD.
- Read path: RSETUP (1 cycle) → RSTROBE (STROBE_CYCLES) → RDONE (1 cycle) → IDLE.
  - `ramDataIn` is captured into `readData` on the edge that leaves the last RSTROBE cycle.
  - `readValid`=1 during RDONE.
- Bus drive per state:
  - `ramCe_n`=0 in every non-IDLE state.
  - `ramWe_n`=0 only in WSTROBE.
  - `ramOe_n`=0 only in RSTROBE/VSTROBE.
  - `ramDataOe`=1 in WSETUP, WSTROBE and WHOLD.
  - `ramAddr`/`ramDataOut` hold the latched values from WSETUP through the last state of the sequence.
- Strobe counter: 4-bit, loaded with STROBE_CYCLES−1 on entry to a STROBE state, decremented each cycle; the state exits when the counter reads 0.
- Outputs are registered or decoded from registered state only; there is no combinational path from the request inputs to the bus.

## Timing
- Reset values, applied immediately on `rst` assertion (mid-sequence included):
  - State IDLE; `busy`=0, `readValid`=0, `writeDone`=0, `illegalReq`=0, `verifyErr`=0.
  - `readData`=0, `ramAddr`=0, `ramDataOut`=0, `ramDataOe`=0.
  - `ramCe_n`=`ramOe_n`=`ramWe_n`=1.
  - An aborted access produces no done or valid pulse.
- Request sampled at edge N: `busy` rises after edge N.
  - Write: `busy` spans STROBE_CYCLES+2 cycles. With default 2, `busy` is high for 4 cycles and `writeDone` is in the 4th.
  - Read: `busy` spans STROBE_CYCLES+2 cycles. `readValid` and the new `readData` appear in the last cycle.
- Back-to-back: a request present in the cycle `busy` falls (first IDLE cycle) is accepted on that edge, so the minimum gap between sequences is 1 IDLE cycle.
- `ramWe_n` never goes low in the same cycle that `ramAddr` changes. WSETUP and WHOLD guarantee 1 cycle of address/data setup and hold.

## Configuration
- `MEM_WRITE_VERIFY_EN` defined:
  - After WHOLD, a write continues VSETUP (1) → VSTROBE (STROBE_CYCLES) → VDONE (1), performing a read of the same address.
  - `writeDone` moves from WHOLD to VDONE. Write `busy` length becomes 2·STROBE_CYCLES+4.
  - If the readback differs from the latched data, `verifyErr` sets in VDONE and stays set until `rst`.
  - `readData` and `readValid` are not affected by verify reads.
- `MEM_WRITE_VERIFY_EN` undefined: no V* states exist, and `verifyErr` is tied 0.

## Test plan
- Reset, then a write of addr 0x0010 with data 0xBEEF (default params):
  - Required: `busy` high 4 cycles; `ramWe_n` low exactly cycles 2–3; `ramDataOe` high cycles 1–4; `writeDone` in cycle 4.
- Read of addr 0x0010 with the SRAM model returning 0xBEEF:
  - Required: `ramOe_n` low cycles 2–3; `readData`=0xBEEF with `readValid` in cycle 4; `readData` holds afterwards.
- `memControl`=11 with `reqValid`:
  - Required: `illegalReq` pulse; a read sequence is performed; `ramWe_n` stays 1 throughout.
- `rst` asserted during WSTROBE:
  - Required: strobes return to 1 and `ramDataOe` to 0 asynchronously; no `writeDone`; the next request is accepted normally.
- Back-to-back write then read, with `reqValid` held:
  - Required: the second request is accepted in the first IDLE cycle; requests presented while `busy` are ignored.
- With `MEM_WRITE_VERIFY_EN` and an SRAM model that corrupts bit 0:
  - Write 0x1234.
  - Required: `writeDone` in cycle 8; `verifyErr`=1 and stays high; `readValid` is never pulsed.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage SRAM access controller: load/store to multi-cycle SRAM bus.
// Optional write readback check under `MEM_WRITE_VERIFY_EN`.
module mem_access_ctrl #(
  parameter int STROBE_CYCLES = 2,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  input  logic [1:0]        memControl,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic [15:0]       dataIn,
  output logic              busy,
  output logic [15:0]       readData,
  output logic              readValid,
  output logic              writeDone,
  output logic              illegalReq,
  output logic              verifyErr,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [15:0]       ramDataOut,
  output logic              ramDataOe,
  input  logic [15:0]       ramDataIn,
  output logic              ramCe_n,
  output logic              ramOe_n,
  output logic              ramWe_n
);

  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WSETUP,
    S_WSTROBE,
    S_WHOLD,
    S_RSETUP,
    S_RSTROBE,
    S_RDONE,
    S_VSETUP,
    S_VSTROBE,
    S_VDONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic [3:0]        r_cnt;
  logic              w_accept;
  logic              w_cntLoad;
  logic              w_oeStrobe;
  logic              w_wrDone;
  logic              r_busy;
  logic [15:0]       r_readData;
  logic              r_readValid;
  logic              r_writeDone;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dout;
  logic              r_doe;
  logic              r_ceN;
  logic              r_oeN;
  logic              r_weN;

  assign w_accept = (r_state == S_IDLE) && reqValid
                    && (memControl != 2'b00);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_nxt = memControl[1] ? S_RSETUP : S_WSETUP;
      end
      S_WSETUP:  w_nxt = S_WSTROBE;
      S_WSTROBE: if (r_cnt == 4'd0) w_nxt = S_WHOLD;
`ifdef MEM_WRITE_VERIFY_EN
      S_WHOLD:   w_nxt = S_VSETUP;
      S_VSETUP:  w_nxt = S_VSTROBE;
      S_VSTROBE: if (r_cnt == 4'd0) w_nxt = S_VDONE;
      S_VDONE:   w_nxt = S_IDLE;
`else
      S_WHOLD:   w_nxt = S_IDLE;
`endif
      S_RSETUP:  w_nxt = S_RSTROBE;
      S_RSTROBE: if (r_cnt == 4'd0) w_nxt = S_RDONE;
      S_RDONE:   w_nxt = S_IDLE;
      default:   w_nxt = S_IDLE;
    endcase
  end

  assign w_cntLoad = (r_state == S_WSETUP)
                     || (r_state == S_RSETUP)
                     || (r_state == S_VSETUP);

`ifdef MEM_WRITE_VERIFY_EN
  logic r_verifyErr;
  assign w_oeStrobe = (w_nxt == S_RSTROBE)
                      || (w_nxt == S_VSTROBE);
  assign w_wrDone   = (w_nxt == S_VDONE);
  assign verifyErr  = r_verifyErr;

  // Compare on the edge leaving the last verify strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_verifyErr <= 1'b0;
    else if (w_nxt == S_VDONE && ramDataIn != r_dout)
      r_verifyErr <= 1'b1;
  end
`else
  assign w_oeStrobe = (w_nxt == S_RSTROBE);
  assign w_wrDone   = (w_nxt == S_WHOLD);
  assign verifyErr  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_busy      <= 1'b0;
      r_readData  <= 16'h0000;
      r_readValid <= 1'b0;
      r_writeDone <= 1'b0;
      r_illegal   <= 1'b0;
      r_addr      <= '0;
      r_dout      <= 16'h0000;
      r_doe       <= 1'b0;
      r_ceN       <= 1'b1;
      r_oeN       <= 1'b1;
      r_weN       <= 1'b1;
    end else begin
      r_state     <= w_nxt;
      r_busy      <= (w_nxt != S_IDLE);
      r_ceN       <= (w_nxt == S_IDLE);
      r_weN       <= (w_nxt != S_WSTROBE);
      r_oeN       <= !w_oeStrobe;
      r_doe       <= (w_nxt == S_WSETUP)
                     || (w_nxt == S_WSTROBE)
                     || (w_nxt == S_WHOLD);
      r_illegal   <= w_accept && (memControl == 2'b11);
      r_writeDone <= w_wrDone;
      r_readValid <= (w_nxt == S_RDONE);
      if (w_accept) begin
        r_addr <= addrIn;
        r_dout <= dataIn;
      end
      if (w_cntLoad)
        r_cnt <= CNT_INIT;
      else if (r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_nxt == S_RDONE)
        r_readData <= ramDataIn;
    end
  end

  assign busy       = r_busy;
  assign readData   = r_readData;
  assign readValid  = r_readValid;
  assign writeDone  = r_writeDone;
  assign illegalReq = r_illegal;
  assign ramAddr    = r_addr;
  assign ramDataOut = r_dout;
  assign ramDataOe  = r_doe;
  assign ramCe_n    = r_ceN;
  assign ramOe_n    = r_oeN;
  assign ramWe_n    = r_weN;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small behavioural SRAM.
// Build with +define+MEM_WRITE_VERIFY_EN to exercise the verify path.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [1:0]  memControl;
  logic [15:0] addrIn;
  logic [15:0] dataIn;
  logic        busy;
  logic [15:0] readData;
  logic        readValid;
  logic        writeDone;
  logic        illegalReq;
  logic        verifyErr;
  logic [15:0] ramAddr;
  logic [15:0] ramDataOut;
  logic        ramDataOe;
  logic [15:0] ramDataIn;
  logic        ramCe_n;
  logic        ramOe_n;
  logic        ramWe_n;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [256];
  logic        corrupt = 1'b0;

  logic [15:0] m_busy, m_we, m_oe, m_doe;
  logic [15:0] m_wd, m_rv, m_ill;
  logic [15:0] rd_cap;
  logic        ve_cap;

`ifdef MEM_WRITE_VERIFY_EN
  localparam int          WR_LEN   = 8;
  localparam logic [15:0] WR_BUSY  = 16'h01FE;
  localparam logic [15:0] WR_OE    = 16'h00C0;
  localparam logic [15:0] WR_WD    = 16'h0100;
  localparam int          BB_RDCAP = 13;
  localparam logic [15:0] BB_BUSY  = 16'h3DFE;
  localparam logic [15:0] BB_OE    = 16'h18C0;
  localparam logic [15:0] BB_RV    = 16'h2000;
`else
  localparam int          WR_LEN   = 4;
  localparam logic [15:0] WR_BUSY  = 16'h001E;
  localparam logic [15:0] WR_OE    = 16'h0000;
  localparam logic [15:0] WR_WD    = 16'h0010;
  localparam int          BB_RDCAP = 9;
  localparam logic [15:0] BB_BUSY  = 16'h03DE;
  localparam logic [15:0] BB_OE    = 16'h0180;
  localparam logic [15:0] BB_RV    = 16'h0200;
`endif

  mem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (reqValid),
    .memControl (memControl),
    .addrIn     (addrIn),
    .dataIn     (dataIn),
    .busy       (busy),
    .readData   (readData),
    .readValid  (readValid),
    .writeDone  (writeDone),
    .illegalReq (illegalReq),
    .verifyErr  (verifyErr),
    .ramAddr    (ramAddr),
    .ramDataOut (ramDataOut),
    .ramDataOe  (ramDataOe),
    .ramDataIn  (ramDataIn),
    .ramCe_n    (ramCe_n),
    .ramOe_n    (ramOe_n),
    .ramWe_n    (ramWe_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!ramCe_n && !ramWe_n)
      mem[ramAddr[7:0]] <= ramDataOut ^ {15'd0, corrupt};

  assign ramDataIn = (ramAddr == 16'h0020) ? 16'hCAFE
                                           : mem[ramAddr[7:0]];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic trace(input int n, input int drop,
                       input bit sw, input int cap);
    m_busy = '0; m_we = '0; m_oe = '0; m_doe = '0;
    m_wd = '0; m_rv = '0; m_ill = '0;
    rd_cap = '0; ve_cap = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      m_busy[c] = busy;
      m_we[c]   = ~ramWe_n;
      m_oe[c]   = ~ramOe_n;
      m_doe[c]  = ramDataOe;
      m_wd[c]   = writeDone;
      m_rv[c]   = readValid;
      m_ill[c]  = illegalReq;
      if (c == cap) begin
        rd_cap = readData;
        ve_cap = verifyErr;
      end
      if (c == drop) reqValid = 1'b0;
      if (sw && c == 1) begin
        memControl = 2'b10;
        addrIn     = 16'h0020;
      end
    end
  endtask

  task automatic request(input logic [1:0] mc,
                         input logic [15:0] a,
                         input logic [15:0] d);
    memControl = mc;
    addrIn     = a;
    dataIn     = d;
    reqValid   = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    reqValid = 1'b0;
    memControl = 2'b00;
    addrIn = '0;
    dataIn = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", readData, 0);
    chk("rst_strobes", {ramCe_n, ramOe_n, ramWe_n}, 3'b111);
    chk("rst_doe", ramDataOe, 0);
    chk("rst_addr", ramAddr, 0);
    chk("rst_verr", verifyErr, 0);
    rst = 1'b0;
    @(negedge clk);

    request(2'b01, 16'h0010, 16'hBEEF);
    trace(10, 1, 0, WR_LEN);
    chk("wr_busy", m_busy, WR_BUSY);
    chk("wr_we", m_we, 16'h000C);
    chk("wr_doe", m_doe, 16'h001E);
    chk("wr_done", m_wd, WR_WD);
    chk("wr_oe", m_oe, WR_OE);
    chk("wr_rv", m_rv, 0);
    chk("wr_verr", verifyErr, 0);

    request(2'b10, 16'h0010, 16'h0000);
    trace(8, 1, 0, 4);
    chk("rd_busy", m_busy, 16'h001E);
    chk("rd_oe", m_oe, 16'h000C);
    chk("rd_we", m_we, 0);
    chk("rd_rv", m_rv, 16'h0010);
    chk("rd_data", rd_cap, 16'hBEEF);
    chk("rd_hold", readData, 16'hBEEF);

    request(2'b11, 16'h0010, 16'h5555);
    trace(8, 1, 0, 4);
    chk("ill_pulse", m_ill, 16'h0002);
    chk("ill_we", m_we, 0);
    chk("ill_doe", m_doe, 0);
    chk("ill_oe", m_oe, 16'h000C);
    chk("ill_rv", m_rv, 16'h0010);
    chk("ill_data", rd_cap, 16'hBEEF);

    request(2'b01, 16'h0030, 16'h1111);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    chk("abort_we_low", ramWe_n, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", {ramCe_n, ramOe_n, ramWe_n}, 3'b111);
    chk("abort_doe", ramDataOe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", readData, 0);
    @(negedge clk);
    rst = 1'b0;
    trace(6, 1, 0, 1);
    chk("abort_wd", m_wd, 0);
    chk("abort_idle", m_busy, 0);
    request(2'b10, 16'h0010, 16'h0000);
    trace(8, 1, 0, 4);
    chk("post_busy", m_busy, 16'h001E);
    chk("post_data", rd_cap, 16'hBEEF);

    request(2'b01, 16'h0050, 16'h7777);
    trace(16, BB_RDCAP - 3, 1, BB_RDCAP);
    chk("b2b_busy", m_busy, BB_BUSY);
    chk("b2b_we", m_we, 16'h000C);
    chk("b2b_oe", m_oe, BB_OE);
    chk("b2b_rv", m_rv, BB_RV);
    chk("b2b_wd", m_wd, WR_WD);
    chk("b2b_data", rd_cap, 16'hCAFE);

`ifdef MEM_WRITE_VERIFY_EN
    corrupt = 1'b1;
    request(2'b01, 16'h0040, 16'h1234);
    trace(10, 1, 0, 8);
    chk("ver_wd", m_wd, 16'h0100);
    chk("ver_rv", m_rv, 0);
    chk("ver_err", ve_cap, 1);
    repeat (3) @(negedge clk);
    chk("ver_sticky", verifyErr, 1);
    chk("ver_rdata", readData, 16'hCAFE);
`else
    chk("verr_tied", verifyErr, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
